// File: rtl/calc_ctrl_fsm.sv
// calc_ctrl_fsm: keypad calculator control FSM (operand entry, operator latch, ALU handshake, display select).
// Defining CALC_BACKSPACE_EN adds the key_bsp input and a_bsp/b_bsp digit-drop strobes.
module calc_ctrl_fsm #(
  parameter int MAX_DIGITS  = 4,
  parameter int OP_W        = 2,
  parameter int ALU_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            key_num,
  input  logic [3:0]      key_val,
  input  logic            key_op,
  input  logic [OP_W-1:0] key_op_code,
  input  logic            key_clr,
  input  logic            key_eq,
`ifdef CALC_BACKSPACE_EN
  input  logic            key_bsp,
  output logic            a_bsp,
  output logic            b_bsp,
`endif
  input  logic            alu_done,
  input  logic            alu_err,
  output logic            a_we,
  output logic            b_we,
  output logic            a_clr,
  output logic            b_clr,
  output logic            res_to_a,
  output logic [3:0]      digit_out,
  output logic            op_we,
  output logic [OP_W-1:0] op_code_out,
  output logic            alu_start,
  output logic [1:0]      disp_sel,
  output logic            err,
  output logic [3:0]      digit_cnt,
  output logic [2:0]      state
);
  typedef enum logic [2:0] {
    S_CLEAR    = 3'd0,
    S_OPA      = 3'd1,
    S_OPB_WAIT = 3'd2,
    S_OPB      = 3'd3,
    S_BUSY     = 3'd4,
    S_RESULT   = 3'd5,
    S_ERROR    = 3'd6
  } state_t;

  localparam int            TW    = $clog2(ALU_TIMEOUT + 1);
  localparam logic [3:0]    MAXD  = 4'(MAX_DIGITS);
  localparam logic [TW-1:0] TLAST = TW'(ALU_TIMEOUT - 1);

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic [3:0]      r_digit;
  logic [OP_W-1:0] r_op;
  logic [TW-1:0]   r_tmo;
  logic [1:0]      r_disp;
  logic            r_err;
  logic            r_pend;
  logic            r_a_we;
  logic            r_b_we;
  logic            r_a_clr;
  logic            r_b_clr;
  logic            r_res_to_a;
  logic            r_op_we;
  logic            r_start;
  logic            w_bsp;
  logic            w_op;
  logic            w_num;
  logic            w_nz;
`ifdef CALC_BACKSPACE_EN
  logic            r_a_bsp;
  logic            r_b_bsp;
`endif

  // {err, disp_sel} shown while in a given state
  function automatic logic [2:0] view(input state_t s);
    return s == S_ERROR ? 3'b100 :
           (s == S_OPB || s == S_BUSY) ? 3'b010 :
           s == S_RESULT ? 3'b011 :
           (s == S_OPA || s == S_OPB_WAIT) ? 3'b001 : 3'b000;
  endfunction

  always_comb begin
`ifdef CALC_BACKSPACE_EN
    w_bsp = key_bsp & ~key_eq;
`else
    w_bsp = 1'b0;
`endif
    w_op  = key_op & ~key_eq & ~w_bsp;
    w_num = key_num & ~key_eq & ~key_op & ~w_bsp;
    w_nz  = key_val != 4'd0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_CLEAR;
      r_disp     <= 2'b00;
      r_err      <= 1'b0;
      r_cnt      <= '0;
      r_tmo      <= '0;
      r_digit    <= '0;
      r_op       <= '0;
      r_pend     <= 1'b0;
      r_a_we     <= 1'b0;
      r_b_we     <= 1'b0;
      r_a_clr    <= 1'b0;
      r_b_clr    <= 1'b0;
      r_res_to_a <= 1'b0;
      r_op_we    <= 1'b0;
      r_start    <= 1'b0;
`ifdef CALC_BACKSPACE_EN
      r_a_bsp    <= 1'b0;
      r_b_bsp    <= 1'b0;
`endif
    end else begin
      r_pend     <= 1'b0;
      r_a_we     <= 1'b0;
      r_b_we     <= 1'b0;
      r_a_clr    <= 1'b0;
      r_b_clr    <= 1'b0;
      r_res_to_a <= 1'b0;
      r_op_we    <= 1'b0;
      r_start    <= 1'b0;
`ifdef CALC_BACKSPACE_EN
      r_a_bsp    <= 1'b0;
      r_b_bsp    <= 1'b0;
`endif
      if (key_clr) begin
        r_state           <= S_CLEAR;
        {r_err, r_disp}   <= view(S_CLEAR);
        r_a_clr           <= 1'b1;
        r_b_clr           <= 1'b1;
        r_cnt             <= '0;
      end else if (r_pend) begin
        // second half of a fresh entry from RESULT: A was cleared last cycle
        r_a_we <= 1'b1;
      end else begin
        case (r_state)
          S_CLEAR: begin
            if (w_num && w_nz) begin
              r_a_we          <= 1'b1;
              r_digit         <= key_val;
              r_cnt           <= 4'd1;
              r_state         <= S_OPA;
              {r_err, r_disp} <= view(S_OPA);
            end
          end
          S_OPA: begin
            if (w_op) begin
              r_op_we         <= 1'b1;
              r_op            <= key_op_code;
              r_b_clr         <= 1'b1;
              r_cnt           <= '0;
              r_state         <= S_OPB_WAIT;
              {r_err, r_disp} <= view(S_OPB_WAIT);
`ifdef CALC_BACKSPACE_EN
            end else if (w_bsp) begin
              if (r_cnt > 4'd1) begin
                r_a_bsp <= 1'b1;
                r_cnt   <= r_cnt - 4'd1;
              end else begin
                r_a_clr         <= 1'b1;
                r_cnt           <= '0;
                r_state         <= S_CLEAR;
                {r_err, r_disp} <= view(S_CLEAR);
              end
`endif
            end else if (w_num && r_cnt < MAXD) begin
              r_a_we  <= 1'b1;
              r_digit <= key_val;
              r_cnt   <= r_cnt + 4'd1;
            end
          end
          S_OPB_WAIT: begin
            if (w_op) begin
              r_op_we <= 1'b1;
              r_op    <= key_op_code;
            end else if (w_num) begin
              r_b_we          <= 1'b1;
              r_digit         <= key_val;
              r_cnt           <= 4'd1;
              r_state         <= S_OPB;
              {r_err, r_disp} <= view(S_OPB);
            end
          end
          S_OPB: begin
            if (key_eq) begin
              r_start         <= 1'b1;
              r_tmo           <= '0;
              r_state         <= S_BUSY;
              {r_err, r_disp} <= view(S_BUSY);
`ifdef CALC_BACKSPACE_EN
            end else if (w_bsp) begin
              if (r_cnt > 4'd1) begin
                r_b_bsp <= 1'b1;
                r_cnt   <= r_cnt - 4'd1;
              end else begin
                r_b_clr         <= 1'b1;
                r_cnt           <= '0;
                r_state         <= S_OPB_WAIT;
                {r_err, r_disp} <= view(S_OPB_WAIT);
              end
`endif
            end else if (w_num && r_cnt < MAXD) begin
              r_b_we  <= 1'b1;
              r_digit <= key_val;
              r_cnt   <= r_cnt + 4'd1;
            end
          end
          S_BUSY: begin
            if (alu_done && alu_err) begin
              r_state         <= S_ERROR;
              {r_err, r_disp} <= view(S_ERROR);
            end else if (alu_done) begin
              r_state         <= S_RESULT;
              {r_err, r_disp} <= view(S_RESULT);
            end else if (r_tmo == TLAST) begin
              r_state         <= S_ERROR;
              {r_err, r_disp} <= view(S_ERROR);
            end else begin
              r_tmo <= r_tmo + TW'(1);
            end
          end
          S_RESULT: begin
            if (key_eq) begin
              r_res_to_a      <= 1'b1;
              r_start         <= 1'b1;
              r_tmo           <= '0;
              r_state         <= S_BUSY;
              {r_err, r_disp} <= view(S_BUSY);
            end else if (w_op) begin
              r_res_to_a      <= 1'b1;
              r_op_we         <= 1'b1;
              r_op            <= key_op_code;
              r_b_clr         <= 1'b1;
              r_cnt           <= '0;
              r_state         <= S_OPB_WAIT;
              {r_err, r_disp} <= view(S_OPB_WAIT);
            end else if (w_num) begin
              r_a_clr <= 1'b1;
              r_b_clr <= 1'b1;
              if (w_nz) begin
                r_pend          <= 1'b1;
                r_digit         <= key_val;
                r_cnt           <= 4'd1;
                r_state         <= S_OPA;
                {r_err, r_disp} <= view(S_OPA);
              end else begin
                r_cnt           <= '0;
                r_state         <= S_CLEAR;
                {r_err, r_disp} <= view(S_CLEAR);
              end
            end
          end
          S_ERROR: ;
          default: begin
            r_state         <= S_ERROR;
            {r_err, r_disp} <= view(S_ERROR);
          end
        endcase
      end
    end
  end

  assign a_we        = r_a_we;
  assign b_we        = r_b_we;
  assign a_clr       = r_a_clr;
  assign b_clr       = r_b_clr;
  assign res_to_a    = r_res_to_a;
  assign digit_out   = r_digit;
  assign op_we       = r_op_we;
  assign op_code_out = r_op;
  assign alu_start   = r_start;
  assign disp_sel    = r_disp;
  assign err         = r_err;
  assign digit_cnt   = r_cnt;
  assign state       = r_state;
`ifdef CALC_BACKSPACE_EN
  assign a_bsp       = r_a_bsp;
  assign b_bsp       = r_b_bsp;
`endif
endmodule

// File: tb/tb_calc_ctrl_fsm.sv
// tb_calc_ctrl_fsm: randomized and directed bench for calc_ctrl_fsm against a queue-based calculator model.
module tb_calc_ctrl_fsm;
  localparam int MAXD = 4;
  localparam int OW   = 2;
  localparam int TMO  = 16;
  localparam int CLEAR = 0, OPA = 1, OPBW = 2, OPB = 3, BUSY = 4, RES = 5, ERR = 6;
  localparam int K_NONE = 0, K_EQ = 1, K_BSP = 2, K_OP = 3, K_NUM = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          key_num = 1'b0, key_op = 1'b0, key_clr = 1'b0, key_eq = 1'b0;
  logic          alu_done = 1'b0, alu_err = 1'b0;
  logic [3:0]    key_val = '0;
  logic [OW-1:0] key_op_code = '0;
  logic          a_we, b_we, a_clr, b_clr, res_to_a, op_we, alu_start, err;
  logic [3:0]    digit_out, digit_cnt;
  logic [OW-1:0] op_code_out;
  logic [1:0]    disp_sel;
  logic [2:0]    state;
`ifdef CALC_BACKSPACE_EN
  logic          key_bsp = 1'b0;
  logic          a_bsp, b_bsp;
`endif

  int errors = 0;
  int checks = 0;

  int m_ph, m_wait, m_sched, m_dig, m_op;
  bit m_pend;
  int a_q[$];
  int b_q[$];
  bit e_a_we, e_b_we, e_a_clr, e_b_clr, e_res, e_op_we, e_start, e_a_bsp, e_b_bsp;
  int disp_tab[7] = '{0, 1, 1, 2, 2, 3, 0};
  int n_a_we, n_b_we, n_op_we, n_start;

  calc_ctrl_fsm #(.MAX_DIGITS(MAXD), .OP_W(OW), .ALU_TIMEOUT(TMO)) dut (
    .clk(clk), .resetn(resetn),
    .key_num(key_num), .key_val(key_val), .key_op(key_op), .key_op_code(key_op_code),
    .key_clr(key_clr), .key_eq(key_eq),
`ifdef CALC_BACKSPACE_EN
    .key_bsp(key_bsp), .a_bsp(a_bsp), .b_bsp(b_bsp),
`endif
    .alu_done(alu_done), .alu_err(alu_err),
    .a_we(a_we), .b_we(b_we), .a_clr(a_clr), .b_clr(b_clr), .res_to_a(res_to_a),
    .digit_out(digit_out), .op_we(op_we), .op_code_out(op_code_out), .alu_start(alu_start),
    .disp_sel(disp_sel), .err(err), .digit_cnt(digit_cnt), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int outs();
    int v;
    v = int'({state, disp_sel, err, digit_cnt, digit_out, op_code_out,
              a_we, b_we, a_clr, b_clr, res_to_a, op_we, alu_start});
`ifdef CALC_BACKSPACE_EN
    v = v | int'({a_bsp, b_bsp});
`endif
    return v;
  endfunction

  task automatic model_reset();
    m_ph = CLEAR; m_wait = 0; m_sched = 0; m_dig = 0; m_op = 0; m_pend = 0;
    a_q.delete(); b_q.delete();
    {e_a_we, e_b_we, e_a_clr, e_b_clr, e_res, e_op_we, e_start, e_a_bsp, e_b_bsp} = '0;
  endtask

  task automatic enter_busy();
    m_ph = BUSY; m_wait = 0; e_start = 1; m_sched = $urandom_range(1, 20);
  endtask

  // Calculator-level rules: what one sampled clock edge must do given the keys present.
  task automatic step(input bit c, e, bs, o, n, input int v, cd, input bit d, ae);
    int k;
    {e_a_we, e_b_we, e_a_clr, e_b_clr, e_res, e_op_we, e_start, e_a_bsp, e_b_bsp} = '0;
    k = e ? K_EQ : bs ? K_BSP : o ? K_OP : n ? K_NUM : K_NONE;
    if (c) begin
      e_a_clr = 1; e_b_clr = 1; a_q.delete(); b_q.delete(); m_ph = CLEAR; m_pend = 0;
    end else if (m_pend) begin
      m_pend = 0; e_a_we = 1;
    end else begin
      case (m_ph)
        CLEAR: if (k == K_NUM && v != 0) begin
          a_q.delete(); a_q.push_back(v); e_a_we = 1; m_dig = v; m_ph = OPA;
        end
        OPA: begin
          if (k == K_OP) begin
            e_op_we = 1; m_op = cd; e_b_clr = 1; b_q.delete(); m_ph = OPBW;
          end else if (k == K_BSP) begin
            if (a_q.size() > 1) begin e_a_bsp = 1; void'(a_q.pop_back()); end
            else begin e_a_clr = 1; a_q.delete(); m_ph = CLEAR; end
          end else if (k == K_NUM && a_q.size() < MAXD) begin
            a_q.push_back(v); e_a_we = 1; m_dig = v;
          end
        end
        OPBW: begin
          if (k == K_OP) begin e_op_we = 1; m_op = cd; end
          else if (k == K_NUM) begin b_q.delete(); b_q.push_back(v); e_b_we = 1; m_dig = v; m_ph = OPB; end
        end
        OPB: begin
          if (k == K_EQ) enter_busy();
          else if (k == K_BSP) begin
            if (b_q.size() > 1) begin e_b_bsp = 1; void'(b_q.pop_back()); end
            else begin e_b_clr = 1; b_q.delete(); m_ph = OPBW; end
          end else if (k == K_NUM && b_q.size() < MAXD) begin
            b_q.push_back(v); e_b_we = 1; m_dig = v;
          end
        end
        BUSY: begin
          if (d) m_ph = ae ? ERR : RES;
          else begin
            m_wait++;
            if (m_wait == TMO) m_ph = ERR;
          end
        end
        RES: begin
          if (k == K_EQ) begin e_res = 1; enter_busy(); end
          else if (k == K_OP) begin
            e_res = 1; e_op_we = 1; m_op = cd; e_b_clr = 1; b_q.delete(); m_ph = OPBW;
          end else if (k == K_NUM) begin
            e_a_clr = 1; e_b_clr = 1; a_q.delete(); b_q.delete();
            if (v != 0) begin m_pend = 1; a_q.push_back(v); m_dig = v; m_ph = OPA; end
            else m_ph = CLEAR;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_all();
    chk("state", int'(state), m_ph);
    chk("disp_sel", int'(disp_sel), disp_tab[m_ph]);
    chk("err", int'(err), int'(m_ph == ERR));
    chk("digit_cnt", int'(digit_cnt), m_ph == OPA ? a_q.size() : b_q.size());
    chk("a_we", int'(a_we), int'(e_a_we));
    chk("b_we", int'(b_we), int'(e_b_we));
    chk("a_clr", int'(a_clr), int'(e_a_clr));
    chk("b_clr", int'(b_clr), int'(e_b_clr));
    chk("res_to_a", int'(res_to_a), int'(e_res));
    chk("op_we", int'(op_we), int'(e_op_we));
    chk("alu_start", int'(alu_start), int'(e_start));
    chk("digit_out", int'(digit_out), m_dig);
    chk("op_code_out", int'(op_code_out), m_op);
`ifdef CALC_BACKSPACE_EN
    chk("a_bsp", int'(a_bsp), int'(e_a_bsp));
    chk("b_bsp", int'(b_bsp), int'(e_b_bsp));
`endif
  endtask

  task automatic tick(input bit c, e, bs, o, n, input int v, cd, input bit d, ae);
`ifndef CALC_BACKSPACE_EN
    bs = 0;
`else
    key_bsp = bs;
`endif
    key_clr = c; key_eq = e; key_op = o; key_num = n;
    key_val = 4'(v); key_op_code = OW'(cd); alu_done = d; alu_err = ae;
    step(c, e, bs, o, n, v, cd, d, ae);
    @(posedge clk);
    @(negedge clk);
    check_all();
    n_a_we += int'(a_we); n_b_we += int'(b_we); n_op_we += int'(op_we); n_start += int'(alu_start);
  endtask

  task automatic t_idle();           tick(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic t_num(input int v); tick(0, 0, 0, 0, 1, v, 0, 0, 0); endtask
  task automatic t_op(input int c);  tick(0, 0, 0, 1, 0, 0, c, 0, 0); endtask
  task automatic t_eq();             tick(0, 1, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic t_clr();            tick(1, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic t_done(input bit e); tick(0, 0, 0, 0, 0, 0, 0, 1, e); endtask
  task automatic clr_counts(); n_a_we = 0; n_b_we = 0; n_op_we = 0; n_start = 0; endtask

  initial begin
    bit c, e, bs, o, n, d, ae;
    int r;
    model_reset();
    clr_counts();
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs(), 0);
    resetn = 1'b1;
    t_idle();
    chk("idle_after_reset", int'(state), 0);

    // 1 2 + 3 = with alu_done three cycles after alu_start
    clr_counts();
    t_num(1); chk("s1_disp_a", int'(disp_sel), 1);
    t_num(2); t_op(0); t_num(3);
    chk("s1_disp_b", int'(disp_sel), 2);
    t_eq();
    t_idle(); t_idle(); t_idle(); t_done(0);
    chk("s1_a_we_count", n_a_we, 2);
    chk("s1_op_we_count", n_op_we, 1);
    chk("s1_b_we_count", n_b_we, 1);
    chk("s1_start_count", n_start, 1);
    chk("s1_state", int'(state), 5);
    chk("s1_disp_res", int'(disp_sel), 3);

    // five digits into a four-digit operand
    t_clr();
    clr_counts();
    for (int i = 1; i <= 5; i++) t_num(i);
    chk("s2_fifth_no_we", int'(a_we), 0);
    chk("s2_a_we_count", n_a_we, 4);
    chk("s2_digit_cnt", int'(digit_cnt), 4);
    chk("s2_digit_out", int'(digit_out), 4);

    // ALU never answers
    t_clr(); t_num(9); t_op(1); t_num(4); t_eq();
    for (int i = 1; i <= 15; i++) t_idle();
    chk("s3_no_err_at_15", int'(err), 0);
    t_idle();
    chk("s3_err_at_16", int'(err), 1);
    t_num(5); t_eq();
    chk("s3_still_error", int'(state), 6);
    t_clr();
    chk("s3_a_clr", int'(a_clr), 1);
    chk("s3_b_clr", int'(b_clr), 1);
    chk("s3_state_clear", int'(state), 0);

    // chaining from RESULT
    t_num(6); t_op(0); t_num(2); t_eq(); t_done(0);
    chk("s4_result", int'(state), 5);
    t_op(2);
    chk("s4_res_to_a", int'(res_to_a), 1);
    chk("s4_op_we", int'(op_we), 1);
    chk("s4_op_code", int'(op_code_out), 2);
    chk("s4_b_clr", int'(b_clr), 1);
    chk("s4_state", int'(state), 2);
    t_eq();
    chk("s4_eq_ignored", int'(alu_start), 0);
    t_num(0);
    chk("s4_zero_b", int'(b_we), 1);
    chk("s4_opb", int'(state), 3);
    t_eq(); t_done(0);
    t_eq();
    chk("s4_repeat_res", int'(res_to_a), 1);
    chk("s4_repeat_start", int'(alu_start), 1);
    t_done(0);
    t_num(4);
    chk("s4_new_a_clr", int'(a_clr), 1);
    chk("s4_new_no_we_yet", int'(a_we), 0);
    t_idle();
    chk("s4_new_a_we", int'(a_we), 1);
    chk("s4_new_digit", int'(digit_out), 4);

    // clear beats a digit in the same cycle
    t_clr(); t_num(3);
    tick(1, 0, 0, 0, 1, 5, 0, 0, 0);
    chk("s5_a_clr", int'(a_clr), 1);
    chk("s5_no_a_we", int'(a_we), 0);
    chk("s5_state", int'(state), 0);

    // asynchronous reset in the middle of BUSY
    t_num(1); t_op(0); t_num(2); t_eq(); t_idle();
    #2 resetn = 1'b0;
    #1 chk("async_reset_outputs", outs(), 0);
    model_reset();
    @(negedge clk);
    resetn = 1'b1;

`ifdef CALC_BACKSPACE_EN
    t_num(7); t_num(8);
    tick(0, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("bsp_a_bsp", int'(a_bsp), 1);
    chk("bsp_cnt", int'(digit_cnt), 1);
    tick(0, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("bsp_a_clr", int'(a_clr), 1);
    chk("bsp_state", int'(state), 0);
`endif

    for (int i = 0; i < 4000; i++) begin
      {c, e, bs, o, n} = '0;
      r = $urandom_range(0, 99);
      if (r >= 45 && r < 70) n = 1;
      else if (r >= 70 && r < 80) o = 1;
      else if (r >= 80 && r < 88) e = 1;
      else if (r >= 88 && r < 93) bs = 1;
      else if (r >= 93 && r < 96) c = 1;
      else if (r >= 96) begin
        n = 1; o = 1'($urandom_range(0, 1)); e = 1'($urandom_range(0, 1)); bs = 1'($urandom_range(0, 1));
      end
      d  = (m_ph == BUSY) ? (m_wait + 1 == m_sched) : ($urandom_range(0, 49) == 0);
      ae = ($urandom_range(0, 3) == 0);
      tick(c, e, bs, o, n, $urandom_range(0, 9), $urandom_range(0, 3), d, ae);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/calc_ctrl_fsm.md
Name: calc_ctrl_fsm

Overview:
- Parametrised next-generation control FSM for the keypad calculator.
- Sequences operand A entry, operator latch, operand B entry, ALU start/done handshake, result display, chained operations and an error state.
- Sits between the keypad decoder (single-cycle key strobes) and the operand registers, ALU and display mux.
- Operand/ALU datapath is external; this block only emits write strobes, selects and handshakes.

Parameters:
- MAX_DIGITS, 4, maximum decimal digits accepted per operand (1..15).
- OP_W, 2, width of the operator code.
- ALU_TIMEOUT, 16, cycles allowed in BUSY before alu_done is declared missing (>=2).

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- key_num  in  1  one-cycle strobe: digit key pressed.
- key_val  in  4  digit value, valid with key_num (0..9).
- key_op  in  1  one-cycle strobe: operator key pressed.
- key_op_code  in  OP_W  operator code, valid with key_op.
- key_clr  in  1  one-cycle strobe: C pressed.
- key_eq  in  1  one-cycle strobe: = pressed.
- alu_done  in  1  ALU result valid, one-cycle pulse.
- alu_err  in  1  ALU error (e.g. div by 0), qualified by alu_done.
- a_we  out  1  shift digit_out into operand A.
- b_we  out  1  shift digit_out into operand B.
- a_clr  out  1  clear operand A.
- b_clr  out  1  clear operand B.
- res_to_a  out  1  copy result register into operand A.
- digit_out  out  4  registered copy of key_val.
- op_we  out  1  latch op_code_out into operator register.
- op_code_out  out  OP_W  registered copy of key_op_code.
- alu_start  out  1  one-cycle ALU start pulse.
- disp_sel  out  2  00 zero, 01 A, 10 B, 11 result.
- err  out  1  high while in ERROR.
- digit_cnt  out  4  digits in the operand currently being entered.
- state  out  3  current state encoding, for debug.

Behaviour:
- Reset (async, resetn=0): state=CLEAR, digit_cnt=0, timeout counter=0, disp_sel=00. All strobe outputs 0; digit_out and op_code_out 0.
- All outputs are registered. A key strobe sampled on edge N produces its response pulses during cycle N+1. Pulses last exactly one cycle.
- Simultaneous key strobes: priority key_clr > key_eq > key_op > key_num. Lower-priority strobes in the same cycle are dropped.
- key_clr in any state: go to CLEAR, pulse a_clr and b_clr, digit_cnt=0.
- States: CLEAR=0, OPA=1, OPB_WAIT=2, OPB=3, BUSY=4, RESULT=5, ERROR=6. Unused encodings go to ERROR.
- CLEAR (disp 00):
  - key_num with key_val=0 is ignored (no leading zero).
  - key_num with key_val!=0: a_we, digit_cnt=1, go to OPA.
- OPA (disp 01):
  - key_num with digit_cnt<MAX_DIGITS: a_we, digit_cnt+1.
  - key_num at MAX_DIGITS: ignored, no strobe.
  - key_op: op_we, b_clr, digit_cnt=0, go to OPB_WAIT.
  - key_eq: ignored.
- OPB_WAIT (disp 01):
  - key_op: op_we again (operator replaced), stay.
  - key_num: b_we, digit_cnt=1, go to OPB. Zero is accepted here.
- OPB (disp 10):
  - key_num: same limit rule as OPA, using b_we.
  - key_eq: alu_start, go to BUSY.
  - key_op: ignored.
- BUSY (disp 10):
  - Key strobes other than key_clr are ignored.
  - alu_done & !alu_err: go to RESULT.
  - alu_done & alu_err: go to ERROR.
  - Timeout counter clears on BUSY entry and increments every BUSY cycle. Reaching ALU_TIMEOUT without alu_done: go to ERROR.
  - key_clr in BUSY aborts; a late alu_done arriving in CLEAR is ignored.
- RESULT (disp 11):
  - key_eq: res_to_a, alu_start, go to BUSY. This repeats the last operator with the last B.
  - key_op: res_to_a, op_we, b_clr, digit_cnt=0, go to OPB_WAIT (chaining).
  - key_num: a_clr, b_clr, then a_we on the following cycle, digit_cnt=1, go to OPA. Nonzero digit only; a zero digit behaves as key_clr.
- ERROR (disp 00, err=1): only key_clr exits.
- digit_cnt saturates and never wraps.

Optional Feature:
- Macro: CALC_BACKSPACE_EN.
- Defined:
  - Adds input port key_bsp (1 bit, one-cycle strobe) and outputs a_bsp and b_bsp (1 bit each). a_bsp/b_bsp tell the operand register to drop its last digit.
  - Priority sits between key_eq and key_op.
  - In OPA/OPB with digit_cnt>1: pulse a_bsp/b_bsp, digit_cnt-1.
  - With digit_cnt=1: a_clr/b_clr, go to CLEAR/OPB_WAIT respectively.
  - Ignored in all other states.
- Not defined: these ports and that logic are absent.

Test Plan:
- Keys 1,2,+,3,= with alu_done 3 cycles after alu_start -> a_we x2, op_we, b_we x1, alu_start once, disp_sel 01→10→11, state ends RESULT.
- MAX_DIGITS=4, press 5 digits in OPA -> exactly 4 a_we pulses, digit_cnt=4, 5th digit produces no strobe.
- In BUSY, hold alu_done low for ALU_TIMEOUT=16 cycles -> err=1 at cycle 17. key_num/key_eq ignored; key_clr -> CLEAR with a_clr and b_clr pulses.
- RESULT then key_op code 2 -> res_to_a, op_we with op_code_out=2, b_clr, state OPB_WAIT. Then key_eq -> no alu_start (ignored).
- key_clr and key_num in the same cycle in OPA -> only a_clr and b_clr, no a_we, state CLEAR. Deassert resetn mid-BUSY -> all outputs 0 immediately.
- CALC_BACKSPACE_EN: digits 7,8 then key_bsp twice -> a_bsp once, digit_cnt 2→1, then a_clr and state CLEAR.
